// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and default latencies.
package md_defs;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/md_sequencer_arith.sv
// Combinational multiply/divide datapath. Division results are packed
// {remainder, quotient} so they land directly in {HI, LO}.
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_by_zero_o
);

    logic signed [63:0] a_sx, b_sx, smul;
    logic [63:0]        umul;
    logic               sgn_div;
    logic [31:0]        dvd, dvs, quo, rem;

    always_comb begin
        a_sx = $signed({{32{a_i[31]}}, a_i});
        b_sx = $signed({{32{b_i[31]}}, b_i});
        smul = a_sx * b_sx;
        umul = {32'b0, a_i} * {32'b0, b_i};

        div_by_zero_o = (b_i == 32'b0);
        sgn_div       = (op_i == MD_DIV);

        // Signed division runs on magnitudes and fixes the signs afterwards;
        // 0x80000000 / -1 falls out naturally as quotient 0x80000000.
        dvd = (sgn_div && a_i[31]) ? -a_i : a_i;
        dvs = (sgn_div && b_i[31]) ? -b_i : b_i;
        if (div_by_zero_o) begin
            dvs = 32'd1;
        end
        quo = dvd / dvs;
        rem = dvd % dvs;
        if (sgn_div && (a_i[31] ^ b_i[31])) begin
            quo = -quo;
        end
        if (sgn_div && a_i[31]) begin
            rem = -rem;
        end

        case (op_i)
            MD_MULT:         result_o = smul;
            MD_MULTU:        result_o = umul;
            MD_DIV, MD_DIVU: result_o = {rem, quo};
            default:         result_o = 64'b0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: launches one fixed-latency MD operation at a time,
// owns HI/LO and requests D-stage stalls while an MD op is in flight.
module md_sequencer
    import md_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXC_flush,
    input  logic        Start_E,
    input  logic [2:0]  MDControl_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        D_uses_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic             commit_q, commit_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    logic [63:0]      arith_res;
    logic             arith_dz;
    logic             accept;
    logic             long_op;

    md_arith u_arith (
        .op_i          (MDControl_E),
        .a_i           (rs_E),
        .b_i           (rt_E),
        .result_o      (arith_res),
        .div_by_zero_o (arith_dz)
    );

    assign busy     = (state_q == RUN);
    assign long_op  = ~MDControl_E[2];
    assign accept   = Start_E & ~EXC_flush & ~busy;
    // Stall also covers the launch cycle, before busy has risen.
    assign md_stall = D_uses_md & (busy | (Start_E & ~EXC_flush & long_op));
    assign HI       = hi_q;
    assign LO       = lo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    case (MDControl_E)
                        MD_MULT, MD_MULTU: begin
                            state_d  = RUN;
                            cnt_d    = CNT_W'(MULT_CYCLES - 1);
                            pend_d   = arith_res;
                            commit_d = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d  = RUN;
                            cnt_d    = CNT_W'(DIV_CYCLES - 1);
                            pend_d   = arith_res;
                            // Divide by zero still burns the full latency but leaves HI/LO alone.
                            commit_d = ~arith_dz;
                        end
                        MD_MTHI: hi_d = rs_E;
                        MD_MTLO: lo_d = rs_E;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (commit_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed cases plus randomized ops checked
// against an arithmetic reference model of the HI/LO architectural state.
module tb_md_sequencer;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        EXC_flush;
    logic        Start_E;
    logic [2:0]  MDControl_E;
    logic [31:0] rs_E, rt_E;
    logic        D_uses_md;
    logic        busy, md_stall;
    logic [31:0] HI, LO;

    md_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .EXC_flush   (EXC_flush),
        .Start_E     (Start_E),
        .MDControl_E (MDControl_E),
        .rs_E        (rs_E),
        .rt_E        (rt_E),
        .D_uses_md   (D_uses_md),
        .busy        (busy),
        .md_stall    (md_stall),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          npass = 0;
    int          ntot  = 0;
    logic [31:0] mhi = 32'b0;
    logic [31:0] mlo = 32'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        ntot++;
        if (act === req) npass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // Reference model: architectural effect of one accepted operation.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int                sa, sb;
        longint            sp;
        longint unsigned   ua, ub, up;
        sa = a;
        sb = b;
        ua = a;
        ub = b;
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); {mhi, mlo} = sp; end
            3'd1: begin up = ua * ub; {mhi, mlo} = up; end
            3'd2: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        mlo = 32'h8000_0000;
                        mhi = 32'h0;
                    end else begin
                        mlo = sa / sb;
                        mhi = sa % sb;
                    end
                end
            end
            3'd3: begin
                if (b != 0) begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
            3'd4: mhi = a;
            3'd5: mlo = a;
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    // Monitor: every time busy falls, the committed HI/LO and the busy length are checked.
    initial begin
        logic prev_busy;
        int   blen;
        exp_t e;
        prev_busy = 1'b0;
        blen      = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                blen      = 0;
            end else begin
                if (busy) blen++;
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_HI", {32'b0, HI}, {32'b0, e.hi});
                        chk("commit_LO", {32'b0, LO}, {32'b0, e.lo});
                        chk("busy_len", 64'(blen), 64'(e.lat));
                    end
                    blen = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // Issue one start; optionally poke flush/start at a given RUN cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd, input logic flush, input int poke_cyc,
                         input logic poke_flush, input logic poke_start);
        int   cyc;
        logic acc_long;
        exp_t e;
        Start_E     = 1'b1;
        MDControl_E = op;
        rs_E        = a;
        rt_E        = b;
        D_uses_md   = dmd;
        EXC_flush   = flush;
        @(negedge clk);
        chk("stall_start", {63'b0, md_stall}, {63'b0, dmd & ~flush & ~op[2]});
        acc_long = ~flush & ~op[2];
        if (!flush) model_op(op, a, b);
        if (acc_long) begin
            e.hi  = mhi;
            e.lo  = mlo;
            e.lat = latency(op);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        Start_E   = 1'b0;
        EXC_flush = 1'b0;
        if (!acc_long) begin
            chk("no_busy", {63'b0, busy}, 64'd0);
            chk("imm_HI", {32'b0, HI}, {32'b0, mhi});
            chk("imm_LO", {32'b0, LO}, {32'b0, mlo});
        end else begin
            cyc = 0;
            while (busy && cyc < 30) begin
                if (cyc == poke_cyc) begin
                    EXC_flush   = poke_flush;
                    Start_E     = poke_start;
                    MDControl_E = MD_MTLO;
                    rs_E        = $urandom;
                end
                @(negedge clk);
                chk("stall_run", {63'b0, md_stall}, {63'b0, dmd});
                @(posedge clk); #1;
                Start_E   = 1'b0;
                EXC_flush = 1'b0;
                cyc++;
            end
            if (busy) chk("busy_timeout", 64'd1, 64'd0);
        end
        D_uses_md = 1'b0;
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        if ($urandom_range(1) == 0) return 32'($urandom_range(200));
        return $urandom;
    endfunction

    initial begin
        reset       = 1'b1;
        EXC_flush   = 1'b0;
        Start_E     = 1'b0;
        MDControl_E = 3'b111;
        rs_E        = 32'b0;
        rt_E        = 32'b0;
        D_uses_md   = 1'b0;
        #12;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_HI", {32'b0, HI}, 64'd0);
        chk("rst_LO", {32'b0, LO}, 64'd0);
        chk("rst_stall", {63'b0, md_stall}, 64'd0);
        D_uses_md = 1'b1;
        #1;
        chk("rst_stall_dmd", {63'b0, md_stall}, 64'd0);
        D_uses_md = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        issue(MD_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        issue(MD_MTLO, 32'h5678, 32'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        issue(MD_DIV, 32'd5, 32'd0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        issue(MD_MULTU, 32'd9, 32'd9, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 4, 1'b0, 1'b1);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, -1, 1'b0, 1'b0);

        // Reset in the middle of a divide.
        issue(MD_MTHI, 32'hDEAD, 32'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        Start_E     = 1'b1;
        MDControl_E = MD_DIV;
        rs_E        = 32'd77;
        rt_E        = 32'd5;
        @(posedge clk); #1;
        Start_E = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_busy", {63'b0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", {63'b0, busy}, 64'd0);
        chk("async_rst_HI", {32'b0, HI}, 64'd0);
        chk("async_rst_LO", {32'b0, LO}, 64'd0);
        mhi = 32'b0;
        mlo = 32'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        issue(MD_MTLO, 32'hA5, 32'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(7)), rand_opnd(), rand_opnd(), 1'($urandom_range(1)),
                  ($urandom_range(5) == 0), int'($urandom_range(9)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
